// File: rtl/dom1_skinny_pkg.sv
// Shared definitions for the DOM-1 Skinny-128-384+ share loader.
// Holds the loader state encoding, field sizes and a helper that
// returns the byte length of the field a given state emits.
package dom1_skinny_pkg;

  localparam int SHARED_BYTES    = 16;  // bytes per shared field (state, key)
  localparam int PASS_BYTES      = 48;  // tweak + counter + seed, forwarded unmasked
  localparam int FRAME_OUT_BYTES = 4 * SHARED_BYTES + PASS_BYTES;  // 112

  typedef enum logic [2:0] {
    S_SH1_ST = 3'd0,
    S_SH0_ST = 3'd1,
    S_SH1_K  = 3'd2,
    S_SH0_K  = 3'd3,
    S_PASS   = 3'd4
  } state_t;

  function automatic logic [5:0] field_len(state_t s);
    return (s == S_PASS) ? 6'(PASS_BYTES) : 6'(SHARED_BYTES);
  endfunction

endpackage

// File: rtl/dom1_share_loader_if.sv
// Byte-stream bundle around the share loader.
// Ports: unmasked input stream (in_*), random stream (rnd_*), masked output (sh_*).
// master = environment side, slave = loader side.
interface dom1_share_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] rnd_data;
  logic       rnd_valid;
  logic       rnd_ready;
  logic [7:0] sh_data;
  logic       sh_valid;
  logic       sh_ready;

  modport master (
    output in_data, in_valid, rnd_data, rnd_valid, sh_ready,
    input  in_ready, rnd_ready, sh_data, sh_valid
  );

  modport slave (
    input  in_data, in_valid, rnd_data, rnd_valid, sh_ready,
    output in_ready, rnd_ready, sh_data, sh_valid
  );
endinterface

// File: rtl/dom1_share_buf.sv
// 16x8 shift buffer holding share0 of one field between its xor-load and shift-out.
// Ports: clk/rst; load_en shifts din in at the bottom, shift_en shifts zeros in;
// dout is the oldest byte (top of the buffer).
module dom1_share_buf
  import dom1_skinny_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_en,
  input  logic       shift_en,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam int W = 8 * SHARED_BYTES;

  logic [W-1:0] shbuf_q, shbuf_d;

  // Zero-fill on shift-out so the buffer holds no residual share once drained.
  always_comb begin
    shbuf_d = shbuf_q;
    if (load_en) begin
      shbuf_d = {shbuf_q[W-9:0], din};
    end else if (shift_en) begin
      shbuf_d = {shbuf_q[W-9:0], 8'h00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shbuf_q <= '0;
    end else begin
      shbuf_q <= shbuf_d;
    end
  end

  assign dout = shbuf_q[W-1 -: 8];

endmodule

// File: rtl/dom1_share_loader.sv
// Splits plaintext and key into two Boolean shares and emits the 112-byte masked
// frame: state sh1, state sh0, key sh1, key sh0, tweak, counter, seed.
// Ports: clk, rst (async active-high), bus (slave side of the byte streams),
// frame_done (one-cycle pulse after the last output byte of a frame).
module dom1_share_loader
  import dom1_skinny_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  dom1_share_loader_if.slave   bus,
  output logic                 frame_done
);

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       frame_done_q, frame_done_d;

  logic [7:0] sh_data_c;
  logic       sh_valid_c, in_ready_c, rnd_ready_c;
  logic       fire, last_byte;
  logic       buf_load, buf_shift;
  logic [7:0] buf_dout;

  // The masked byte is only ever written into the buffer; it reaches sh_data
  // one field later, after it has been registered.
  dom1_share_buf u_buf (
    .clk      (clk),
    .rst      (rst),
    .load_en  (buf_load),
    .shift_en (buf_shift),
    .din      (bus.in_data ^ bus.rnd_data),
    .dout     (buf_dout)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    sh_data_c    = 8'h00;
    sh_valid_c   = 1'b0;
    in_ready_c   = 1'b0;
    rnd_ready_c  = 1'b0;
    buf_load     = 1'b0;
    buf_shift    = 1'b0;

    case (state_q)
      S_SH1_ST, S_SH1_K: begin
        // Both streams must be present; each side's ready waits on the other's
        // valid so neither a plain nor a random byte is consumed alone.
        sh_data_c   = bus.rnd_data;
        sh_valid_c  = bus.in_valid & bus.rnd_valid;
        in_ready_c  = bus.sh_ready & bus.rnd_valid;
        rnd_ready_c = bus.sh_ready & bus.in_valid;
      end
      S_SH0_ST, S_SH0_K: begin
        sh_data_c  = buf_dout;
        sh_valid_c = 1'b1;
      end
      S_PASS: begin
        sh_data_c  = bus.in_data;
        sh_valid_c = bus.in_valid;
        in_ready_c = bus.sh_ready;
      end
      default: ;
    endcase

    // Outputs fall to idle the moment reset is raised, not at the next edge.
    if (rst) begin
      sh_valid_c  = 1'b0;
      in_ready_c  = 1'b0;
      rnd_ready_c = 1'b0;
    end

    fire      = sh_valid_c & bus.sh_ready;
    last_byte = (cnt_q == field_len(state_q) - 6'd1);

    if (fire) begin
      cnt_d = cnt_q + 6'd1;
      case (state_q)
        S_SH1_ST, S_SH1_K: buf_load  = 1'b1;
        S_SH0_ST, S_SH0_K: buf_shift = 1'b1;
        default: ;
      endcase
      if (last_byte) begin
        cnt_d = 6'd0;
        case (state_q)
          S_SH1_ST: state_d = S_SH0_ST;
          S_SH0_ST: state_d = S_SH1_K;
          S_SH1_K:  state_d = S_SH0_K;
          S_SH0_K:  state_d = S_PASS;
          default: begin
            state_d      = S_SH1_ST;
            frame_done_d = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_SH1_ST;
      cnt_q        <= 6'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.sh_data   = sh_data_c;
  assign bus.sh_valid  = sh_valid_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.rnd_ready = rnd_ready_c;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_dom1_share_loader.sv
// Testbench for dom1_share_loader: table of frame scenarios plus a mid-frame
// reset sequence; expected bytes are queued when a frame is loaded and popped
// on every output fire.
module tb_dom1_share_loader;
  import dom1_skinny_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic frame_done;

  always #5 clk = ~clk;

  dom1_share_loader_if bus();

  dom1_share_loader dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .frame_done (frame_done)
  );

  int n_vec = 0;
  int n_err = 0;
  int fires_total = 0;

  logic [7:0] in_q[$];
  logic [7:0] rnd_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] in_base;
    logic [7:0] rnd_base;
    bit         zero_rnd;
    bit         toggle;
    bit         gap;
    int         n_frames;
    int         exp_cycles;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Queue one frame's input and random bytes, and the 112 bytes it must produce.
  task automatic load_frame(input logic [7:0] in_base, input logic [7:0] rnd_base,
                            input bit zero_rnd);
    logic [7:0] pin[80];
    logic [7:0] r[32];
    for (int k = 0; k < 80; k++) begin
      pin[k] = in_base + 8'(k);
      in_q.push_back(pin[k]);
    end
    for (int k = 0; k < 32; k++) begin
      r[k] = zero_rnd ? 8'h00 : rnd_base + 8'(k);
      rnd_q.push_back(r[k]);
    end
    for (int i = 0; i < 16; i++) exp_q.push_back(r[i]);
    for (int i = 0; i < 16; i++) exp_q.push_back(pin[i] ^ r[i]);
    for (int i = 0; i < 16; i++) exp_q.push_back(r[16+i]);
    for (int i = 0; i < 16; i++) exp_q.push_back(pin[16+i] ^ r[16+i]);
    for (int i = 0; i < 48; i++) exp_q.push_back(pin[32+i]);
  endtask

  // Drive queued streams until the scoreboard drains (or stop_after bytes fire).
  // cycles = index of the cycle holding the last fire, plus one.
  task automatic run(input bit toggle, input bit gap, input int stop_after,
                     output int cycles, output int fired);
    int         cyc = 0;
    int         rnd_taken = 0;
    int         gap_left = 0;
    bit         fd_exp = 1'b0;
    bit         stalled = 1'b0;
    bit         fire;
    logic [7:0] held = 8'h00;
    fired  = 0;
    cycles = 0;
    while (((exp_q.size() != 0 && fired < stop_after) || fd_exp) && cyc < 2000) begin
      @(negedge clk);
      bus.in_valid = (in_q.size() != 0);
      bus.in_data  = (in_q.size() != 0) ? in_q[0] : 8'h00;
      if (gap_left > 0 || rnd_q.size() == 0) begin
        bus.rnd_valid = 1'b0;
        bus.rnd_data  = 8'h00;
      end else begin
        bus.rnd_valid = 1'b1;
        bus.rnd_data  = rnd_q[0];
      end
      bus.sh_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      #1;
      check("frame_done", 32'(frame_done), 32'(fd_exp));
      if (stalled) begin
        check("stall_valid", 32'(bus.sh_valid), 32'd1);
        check("stall_data", 32'(bus.sh_data), 32'(held));
      end
      if (gap_left > 0) begin
        check("gap_sh_valid", 32'(bus.sh_valid), 32'd0);
        check("gap_in_ready", 32'(bus.in_ready), 32'd0);
        gap_left--;
      end
      fd_exp = 1'b0;
      fire = bus.sh_valid & bus.sh_ready;
      if (fire) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_byte: got %0h, expected no output", bus.sh_data);
        end else begin
          check($sformatf("byte%0d", fired), 32'(bus.sh_data), 32'(exp_q.pop_front()));
        end
        fired++;
        fires_total++;
        if (fires_total % FRAME_OUT_BYTES == 0) fd_exp = 1'b1;
        cycles = cyc + 1;
      end
      stalled = bus.sh_valid & ~bus.sh_ready;
      held    = bus.sh_data;
      if (bus.in_valid & bus.in_ready) void'(in_q.pop_front());
      if (bus.rnd_valid & bus.rnd_ready) begin
        void'(rnd_q.pop_front());
        rnd_taken++;
        if (gap && rnd_taken == 8) gap_left = 5;
      end
      cyc++;
    end
    if (cyc >= 2000) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: %0d bytes out after %0d cycles, %0d still expected",
               fired, cyc, exp_q.size());
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.rnd_valid = 1'b0;
    bus.rnd_data  = 8'h00;
    bus.sh_ready  = 1'b0;
  endtask

  vec_t vecs[5];
  int   cyc_out;
  int   fired_out;

  initial begin
    // in_base, rnd_base, zero_rnd, toggle, gap, n_frames, exp_cycles
    vecs[0] = '{8'h00, 8'hA0, 1'b0, 1'b0, 1'b0, 1, 112};  // basic frame
    vecs[1] = '{8'h00, 8'hA0, 1'b0, 1'b0, 1'b1, 1, 117};  // 5-cycle rnd gap after byte 7
    vecs[2] = '{8'h00, 8'hA0, 1'b0, 1'b1, 1'b0, 1, 224};  // sh_ready toggling
    vecs[3] = '{8'h00, 8'hA0, 1'b0, 1'b0, 1'b0, 2, 224};  // back-to-back frames
    vecs[4] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1, 112};  // zero randomness

    rst = 1'b1;
    idle_inputs();
    bus.in_valid  = 1'b1;
    bus.rnd_valid = 1'b1;
    bus.sh_ready  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_sh_valid", 32'(bus.sh_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_rnd_ready", 32'(bus.rnd_ready), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_buf", 32'(|dut.u_buf.shbuf_q), 32'd0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_state", 32'(dut.state_q), 32'(S_SH1_ST));
    check("rst_cnt", 32'(dut.cnt_q), 32'd0);

    for (int v = 0; v < 5; v++) begin
      for (int f = 0; f < vecs[v].n_frames; f++) begin
        load_frame(vecs[v].in_base + 8'(80 * f), vecs[v].rnd_base + 8'(32 * f),
                   vecs[v].zero_rnd);
      end
      run(vecs[v].toggle, vecs[v].gap, 1 << 30, cyc_out, fired_out);
      check($sformatf("v%0d_cycles", v), 32'(cyc_out), 32'(vecs[v].exp_cycles));
      check($sformatf("v%0d_bytes", v), 32'(fired_out), 32'(FRAME_OUT_BYTES * vecs[v].n_frames));
      check($sformatf("v%0d_buf_exit", v), 32'(|dut.u_buf.shbuf_q), 32'd0);
      check($sformatf("v%0d_state_exit", v), 32'(dut.state_q), 32'(S_SH1_ST));
    end

    // Abort mid-frame: reset lands while state share0 is being shifted out.
    load_frame(8'h00, 8'hA0, 1'b0);
    run(1'b0, 1'b0, 20, cyc_out, fired_out);
    check("abort_bytes", 32'(fired_out), 32'd20);
    @(negedge clk);
    check("abort_buf_live", 32'(|dut.u_buf.shbuf_q), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_sh_valid", 32'(bus.sh_valid), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd0);
    check("abort_rnd_ready", 32'(bus.rnd_ready), 32'd0);
    check("abort_frame_done", 32'(frame_done), 32'd0);
    check("abort_buf", 32'(|dut.u_buf.shbuf_q), 32'd0);
    check("abort_state", 32'(dut.state_q), 32'(S_SH1_ST));
    in_q.delete();
    rnd_q.delete();
    exp_q.delete();
    fires_total = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    load_frame(8'h00, 8'hA0, 1'b0);
    run(1'b0, 1'b0, 1 << 30, cyc_out, fired_out);
    check("post_rst_cycles", 32'(cyc_out), 32'd112);
    check("post_rst_bytes", 32'(fired_out), 32'd112);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
